// File: rtl/ula_pkg.sv
// ==== ula_pkg : shared state type and 74181 select constants  (rev 1.0) ====
`default_nettype none

package ula_pkg;

   typedef enum logic [0:0] {
      OCIOSO = 1'b0,
      CALC   = 1'b1
   } state_t;

   // Common selects: SOMA/SUB are arithmetic (m=0), XOR is logic (m=1).
   localparam logic [3:0] S_SOMA = 4'b1001;
   localparam logic [3:0] S_SUB  = 4'b0110;
   localparam logic [3:0] S_XOR  = 4'b0110;

endpackage : ula_pkg

`default_nettype wire

// File: rtl/ula_74181.sv
// ==== ula_74181 : 4-bit 74181 ALU slice, active-high data, active-low carries  (rev 1.0) ====
`default_nettype none

module ula_74181 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       c_in,
   output logic [3:0] f,
   output logic       c_out,
   output logic       a_eq_b
);

   logic [3:0] or_term;
   logic [3:0] and_term;
   logic [4:0] sum;

   // Arithmetic result is or_term + and_term + carry; the logic functions fall
   // out as the inverted XOR of the same two terms.
   always_comb begin
      or_term  = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
      and_term = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
      sum      = {1'b0, or_term} + {1'b0, and_term} + {4'b0000, ~c_in};
      f        = m ? ~(or_term ^ and_term) : sum[3:0];
      c_out    = ~sum[4];
      a_eq_b   = &f;
   end

endmodule : ula_74181

`default_nettype wire

// File: rtl/ula_seq_nibble.sv
// ==== ula_seq_nibble : LARGURA-bit 74181 operation, one nibble per clock  (rev 1.0) ====
`default_nettype none

module ula_seq_nibble
   import ula_pkg::*;
#(
   parameter int LARGURA = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [3:0]         op_s,
   input  logic               op_m,
   input  logic               op_cin,
   input  logic [LARGURA-1:0] op_a,
   input  logic [LARGURA-1:0] op_b,
   output logic               busy,
   output logic               done,
   output logic [LARGURA-1:0] res_f,
   output logic               res_cout,
   output logic               res_a_eq_b
);

   localparam int N   = LARGURA / 4;
   localparam int K_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

   state_t               state_q, state_d;
   logic [K_W-1:0]       k_q, k_d;
   logic                 carry_q, carry_d;
   logic                 eq_q, eq_d;
   logic [LARGURA-1:0]   shadow_q, shadow_d;
   logic [LARGURA-1:0]   a_q, a_d;
   logic [LARGURA-1:0]   b_q, b_d;
   logic [3:0]           s_q, s_d;
   logic                 m_q, m_d;
   logic [LARGURA-1:0]   res_f_q, res_f_d;
   logic                 res_cout_q, res_cout_d;
   logic                 res_eq_q, res_eq_d;
   logic                 done_q, done_d;

   logic [3:0]           slice_f;
   logic                 slice_cout;
   logic                 slice_eq;

   ula_74181 u_slice (
      .a      (a_q[4*k_q +: 4]),
      .b      (b_q[4*k_q +: 4]),
      .s      (s_q),
      .m      (m_q),
      .c_in   (carry_q),
      .f      (slice_f),
      .c_out  (slice_cout),
      .a_eq_b (slice_eq)
   );

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      carry_d    = carry_q;
      eq_d       = eq_q;
      shadow_d   = shadow_q;
      a_d        = a_q;
      b_d        = b_q;
      s_d        = s_q;
      m_d        = m_q;
      res_f_d    = res_f_q;
      res_cout_d = res_cout_q;
      res_eq_d   = res_eq_q;
      done_d     = 1'b0;
      case (state_q)
         OCIOSO: begin
            if (start) begin
               a_d     = op_a;
               b_d     = op_b;
               s_d     = op_s;
               m_d     = op_m;
               carry_d = op_cin;
               eq_d    = 1'b1;
               k_d     = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            shadow_d[4*k_q +: 4] = slice_f;
            carry_d              = slice_cout;
            eq_d                 = eq_q & slice_eq;
            k_d                  = k_q + K_W'(1);
            // Last nibble: publish the whole word in one step so res_* never
            // shows a partially built result.
            if (k_q == K_LAST) begin
               res_f_d    = shadow_d;
               res_cout_d = slice_cout;
               res_eq_d   = eq_q & slice_eq;
               done_d     = 1'b1;
               k_d        = '0;
               state_d    = OCIOSO;
            end
         end
         default: state_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= OCIOSO;
         k_q        <= '0;
         carry_q    <= 1'b1;
         eq_q       <= 1'b0;
         shadow_q   <= '0;
         a_q        <= '0;
         b_q        <= '0;
         s_q        <= '0;
         m_q        <= 1'b0;
         res_f_q    <= '0;
         res_cout_q <= 1'b0;
         res_eq_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         carry_q    <= carry_d;
         eq_q       <= eq_d;
         shadow_q   <= shadow_d;
         a_q        <= a_d;
         b_q        <= b_d;
         s_q        <= s_d;
         m_q        <= m_d;
         res_f_q    <= res_f_d;
         res_cout_q <= res_cout_d;
         res_eq_q   <= res_eq_d;
         done_q     <= done_d;
      end
   end

   assign busy       = (state_q == CALC);
   assign done       = done_q;
   assign res_f      = res_f_q;
   assign res_cout   = res_cout_q;
   assign res_a_eq_b = res_eq_q;

endmodule : ula_seq_nibble

`default_nettype wire

// File: tb/tb_ula_seq_nibble.sv
// ==== tb_ula_seq_nibble : scoreboard bench for the nibble-serial 74181 sequencer  (rev 1.0) ====
`default_nettype none

module tb_ula_seq_nibble;
   import ula_pkg::*;

   localparam int LARGURA = 16;
   localparam int N       = LARGURA / 4;
   localparam int BUDGET  = 3 * N + 6;

   typedef struct {
      logic [LARGURA-1:0] f;
      logic               cout;
      logic               eq;
   } exp_t;

   typedef struct {
      logic [3:0]         s;
      logic               m;
      logic               cin;
      logic [LARGURA-1:0] a;
      logic [LARGURA-1:0] b;
      logic [LARGURA-1:0] f;
      logic               cout;
      logic               eq;
   } vec_t;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [3:0]         op_s;
   logic               op_m;
   logic               op_cin;
   logic [LARGURA-1:0] op_a;
   logic [LARGURA-1:0] op_b;
   logic               busy;
   logic               done;
   logic [LARGURA-1:0] res_f;
   logic               res_cout;
   logic               res_a_eq_b;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   ula_seq_nibble #(.LARGURA(LARGURA)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .op_s       (op_s),
      .op_m       (op_m),
      .op_cin     (op_cin),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .done       (done),
      .res_f      (res_f),
      .res_cout   (res_cout),
      .res_a_eq_b (res_a_eq_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one request at a falling edge, record its expectation, and return
   // 1 time unit after the accepting rising edge with start already dropped.
   task automatic launch(input vec_t v);
      @(negedge clk);
      op_s   = v.s;
      op_m   = v.m;
      op_cin = v.cin;
      op_a   = v.a;
      op_b   = v.b;
      start  = 1'b1;
      exp_q.push_back('{f: v.f, cout: v.cout, eq: v.eq});
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts rising edges until done is seen; lat = edges after the accept edge.
   task automatic wait_done(output bit seen, output int lat);
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= BUDGET; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            seen = 1'b1;
            lat  = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      op_s  = '0; op_m = 1'b0; op_cin = 1'b1; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, res_cout, res_a_eq_b} !== 4'b0000 || res_f !== '0)
         $display("FAIL reset_state: busy=%b done=%b f=%h cout=%b eq=%b, required all zero",
                  busy, done, res_f, res_cout, res_a_eq_b);
      if ({busy, done, res_cout, res_a_eq_b} !== 4'b0000 || res_f !== '0) failures++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs a table of vectors; each result is checked against the scoreboard.
   task automatic test_vectors(input string tag, input vec_t vs[]);
      bit   seen;
      int   lat;
      exp_t e;
      foreach (vs[i]) begin
         launch(vs[i]);
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s[%0d]_busy: busy=%b, required 1", tag, i, busy);
         end
         wait_done(seen, lat);
         checks++;
         if (!seen || lat != N) begin
            failures++;
            $display("FAIL %s[%0d]_latency: seen=%b edges=%0d, required %0d", tag, i, seen, lat, N);
         end
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s[%0d]_scoreboard: queue empty, required one entry", tag, i);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (res_f !== e.f || res_cout !== e.cout || res_a_eq_b !== e.eq || busy !== 1'b0) begin
               failures++;
               $display("FAIL %s[%0d]_result: f=%h cout=%b eq=%b busy=%b, required f=%h cout=%b eq=%b busy=0",
                        tag, i, res_f, res_cout, res_a_eq_b, busy, e.f, e.cout, e.eq);
            end
         end
      end
   endtask

   task automatic test_arith;
      vec_t vs[] = '{
         '{s: S_SOMA, m: 1'b0, cin: 1'b1, a: 16'h1234, b: 16'h0FFF, f: 16'h2233, cout: 1'b1, eq: 1'b0},
         '{s: S_SOMA, m: 1'b0, cin: 1'b1, a: 16'hFFFF, b: 16'h0001, f: 16'h0000, cout: 1'b0, eq: 1'b0},
         '{s: S_SUB,  m: 1'b0, cin: 1'b0, a: 16'h1000, b: 16'h0001, f: 16'h0FFF, cout: 1'b0, eq: 1'b0}
      };
      test_vectors("arith", vs);
   endtask

   task automatic test_logic_eq;
      // Equality uses A-B-1 with no carry in: all-ones per nibble when equal.
      vec_t vs[] = '{
         '{s: S_XOR, m: 1'b1, cin: 1'b1, a: 16'hA5A5, b: 16'h0FF0, f: 16'hAA55, cout: 1'b0, eq: 1'b0},
         '{s: S_SUB, m: 1'b0, cin: 1'b1, a: 16'h5A5A, b: 16'h5A5A, f: 16'hFFFF, cout: 1'b1, eq: 1'b1},
         '{s: S_SUB, m: 1'b0, cin: 1'b1, a: 16'h5A5B, b: 16'h5A5A, f: 16'h0000, cout: 1'b0, eq: 1'b0}
      };
      test_vectors("logic_eq", vs);
   endtask

   task automatic test_hold_start;
      int   n_done;
      exp_t e;
      n_done = 0;
      @(negedge clk);
      op_s = S_SOMA; op_m = 1'b0; op_cin = 1'b1; op_a = 16'h0001; op_b = 16'h0001;
      start = 1'b1;
      exp_q.push_back('{f: 16'h0002, cout: 1'b1, eq: 1'b0});
      for (int i = 0; i <= N + 6; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) n_done++;
         if (i == N) start = 1'b0;
      end
      checks++;
      if (n_done != 1) begin
         failures++;
         $display("FAIL hold_start_count: done pulses=%0d, required 1", n_done);
      end
      e = exp_q.pop_front();
      checks++;
      if (res_f !== e.f || res_cout !== e.cout || busy !== 1'b0) begin
         failures++;
         $display("FAIL hold_start_result: f=%h cout=%b busy=%b, required f=%h cout=%b busy=0",
                  res_f, res_cout, busy, e.f, e.cout);
      end
   endtask

   task automatic test_back_to_back;
      bit   seen;
      int   lat;
      exp_t e;
      launch('{s: S_SOMA, m: 1'b0, cin: 1'b1, a: 16'h00FF, b: 16'h0001,
               f: 16'h0100, cout: 1'b1, eq: 1'b0});
      wait_done(seen, lat);
      e = exp_q.pop_front();
      checks++;
      if (!seen || res_f !== e.f) begin
         failures++;
         $display("FAIL b2b_first: seen=%b f=%h, required seen=1 f=%h", seen, res_f, e.f);
      end
      // Still inside the done cycle: this request is accepted at the next edge.
      op_a = 16'h0001; op_b = 16'h0002; op_cin = 1'b1; op_s = S_SOMA; op_m = 1'b0;
      start = 1'b1;
      exp_q.push_back('{f: 16'h0003, cout: 1'b1, eq: 1'b0});
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept: busy=%b, required 1", busy);
      end
      wait_done(seen, lat);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != N || res_f !== e.f || res_cout !== e.cout) begin
         failures++;
         $display("FAIL b2b_second: seen=%b edges=%0d f=%h cout=%b, required edges=%0d f=%h cout=%b",
                  seen, lat, res_f, res_cout, N, e.f, e.cout);
      end
   endtask

   task automatic test_op_change;
      bit   seen;
      int   lat;
      exp_t e;
      launch('{s: S_SOMA, m: 1'b0, cin: 1'b1, a: 16'h1111, b: 16'h2222,
               f: 16'h3333, cout: 1'b1, eq: 1'b0});
      op_a = 16'hFFFF; op_b = 16'h0000; op_cin = 1'b0; op_s = 4'b0000; op_m = 1'b1;
      checks++;
      if (res_f === 16'h3333) begin
         failures++;
         $display("FAIL op_change_stable: f=%h changed before commit, required previous result", res_f);
      end
      wait_done(seen, lat);
      e = exp_q.pop_front();
      checks++;
      if (!seen || res_f !== e.f || res_cout !== e.cout) begin
         failures++;
         $display("FAIL op_change_result: seen=%b f=%h cout=%b, required f=%h cout=%b",
                  seen, res_f, res_cout, e.f, e.cout);
      end
   endtask

   task automatic test_mid_reset;
      int n_done;
      n_done = 0;
      launch('{s: S_SOMA, m: 1'b0, cin: 1'b1, a: 16'h4444, b: 16'h1111,
               f: 16'h5555, cout: 1'b1, eq: 1'b0});
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || res_f !== '0 || res_cout !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: busy=%b done=%b f=%h cout=%b, required all zero",
                  busy, done, res_f, res_cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2 * N + 2; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) n_done++;
      end
      checks++;
      if (n_done != 0 || busy !== 1'b0 || res_f !== '0) begin
         failures++;
         $display("FAIL mid_reset_release: done pulses=%0d busy=%b f=%h, required 0/0/0000",
                  n_done, busy, res_f);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic_eq();
      test_hold_start();
      test_back_to_back();
      test_op_change();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ula_seq_nibble

`default_nettype wire
